// File: rtl/toy_phy_reg_freelist.sv
// toy_phy_reg_freelist: circular free list of physical register ids with flush recovery to the committed head.
// Optional consistency checker driving err is built only when FREELIST_CHK_EN is defined.
module toy_phy_reg_freelist #(
  parameter int MODE = 0,
  parameter int PHY_REG_NUM = 64,
  parameter int ARCH_ENTRY_NUM = 32,
  parameter int ALLOC_CH = 4,
  parameter int REL_CH = 4,
  parameter int DEPTH = PHY_REG_NUM - ARCH_ENTRY_NUM,
  parameter int PRW = $clog2(PHY_REG_NUM),
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_CH-1:0]           v_alloc_req,
  output logic                          alloc_gnt,
  output logic [ALLOC_CH-1:0][PRW-1:0]  v_alloc_phy_id,
  input  logic [REL_CH-1:0]             v_rel_en,
  input  logic [REL_CH-1:0][PRW-1:0]    v_rel_index,
  input  logic [REL_CH-1:0]             v_commit_alloc_en,
  input  logic                          flush,
  output logic [AW:0]                   free_cnt,
  output logic                          err
);
  if (MODE < 0 || MODE > 1) begin : g_bad_mode
    $error("MODE must be 0 (INT) or 1 (FP)");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two");
  end
  logic [PRW-1:0] entry [DEPTH];
  logic [AW:0] head, tail, cmt_head, head_next, tail_next, cmt_next;
  logic [AW:0] n_req, n_rel, n_cmt;
  logic [AW:0] alloc_off [ALLOC_CH];
  logic [AW-1:0] wr_addr [REL_CH];
  assign free_cnt = tail - head;
  assign n_cmt = (AW+1)'($countones(v_commit_alloc_en));
  always_comb begin
    logic [AW:0] acc;
    acc = '0;
    for (int k = 0; k < ALLOC_CH; k++) begin
      alloc_off[k] = acc;
      acc = acc + (AW+1)'(v_alloc_req[k]);
    end
    n_req = acc;
  end
  always_comb begin
    for (int k = 0; k < ALLOC_CH; k++) v_alloc_phy_id[k] = entry[AW'(head + alloc_off[k])];
  end
  // enabled release lanes are packed densely starting at tail
  always_comb begin
    logic [AW:0] acc;
    acc = '0;
    for (int j = 0; j < REL_CH; j++) begin
      wr_addr[j] = AW'(tail + acc);
      acc = acc + (AW+1)'(v_rel_en[j]);
    end
    n_rel = acc;
  end
  always_comb begin
    alloc_gnt = (free_cnt >= n_req) && !flush;
    cmt_next = cmt_head + n_cmt;
    tail_next = tail + n_rel;
    head_next = flush ? cmt_next : alloc_gnt ? head + n_req : head;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      cmt_head <= '0;
      tail <= (AW+1)'(DEPTH);
    end else begin
      head <= head_next;
      cmt_head <= cmt_next;
      tail <= tail_next;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= PRW'(ARCH_ENTRY_NUM + i);
    end else begin
      for (int j = 0; j < REL_CH; j++) if (v_rel_en[j]) entry[wr_addr[j]] <= v_rel_index[j];
    end
  end
`ifdef FREELIST_CHK_EN
  logic first, bad;
  always_comb begin
    bad = ((AW+2)'(free_cnt) + (AW+2)'(n_rel)) > (AW+2)'(DEPTH);
    bad = bad | ((head_next - cmt_next) > (AW+1)'(DEPTH));
    for (int j = 0; j < REL_CH; j++)
      if (v_rel_en[j] && (32'(v_rel_index[j]) >= PHY_REG_NUM || (first && 32'(v_rel_index[j]) < ARCH_ENTRY_NUM)))
        bad = 1'b1;
  end
  // first marks the single cycle right after reset, when only non-architectural ids may come back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (bad) err <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (!rst && bad && !err) $error("freelist MODE %0d consistency violation", MODE);
`else
  assign err = 1'b0;
`endif
endmodule
